// File: rtl/hdc_text_pkg.sv
// Shared types and ASCII constants for the text encoder controller.
package hdc_text_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StFlush,
        StDone,
        StWait,
        StOut
    } textState_t;

    localparam logic [7:0] AsciiSpace  = 8'd32;
    localparam logic [7:0] AsciiLowerA = 8'd97;
    localparam logic [7:0] AsciiLowerZ = 8'd122;
    localparam logic [7:0] AsciiUpperA = 8'd65;
    localparam logic [7:0] AsciiUpperZ = 8'd90;

    localparam int unsigned MaxLettersDefault = 27;

endpackage

// File: rtl/text_encoder_ctrl_char_mapper.sv
// Combinational ASCII-to-letter-index mapper.
// Uppercase letters map like lowercase only when TEXT_CTRL_UPPERCASE_EN is defined.
module char_mapper
    import hdc_text_pkg::*;
#(
    parameter int unsigned MAXLETTERS = MaxLettersDefault
) (
    input  logic [7:0] code,
    output logic [4:0] index,
    output logic       valid
);

    localparam logic [4:0] SpaceIdx = 5'(MAXLETTERS - 1);

    always_comb begin
        index = '0;
        valid = 1'b0;
        if (code == AsciiSpace) begin
            index = SpaceIdx;
            valid = 1'b1;
        end else if (code >= AsciiLowerA && code <= AsciiLowerZ) begin
            index = 5'(code - AsciiLowerA);
            valid = 1'b1;
        end
`ifdef TEXT_CTRL_UPPERCASE_EN
        else if (code >= AsciiUpperA && code <= AsciiUpperZ) begin
            index = 5'(code - AsciiUpperA);
            valid = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/text_encoder_ctrl.sv
// Streams ASCII text into random_index_block and sequences its clear/done/output phases.
// Optional feature macro: TEXT_CTRL_UPPERCASE_EN (handled inside char_mapper).
module text_encoder_ctrl
    import hdc_text_pkg::*;
#(
    parameter int unsigned MAXLETTERS = MaxLettersDefault,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DONE_WAIT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    input  logic             char_last,
    output logic             char_ready,
    output logic             letterReady,
    output logic [4:0]       inputLetter,
    output logic             textDone,
    output logic             rst_RI,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [CNT_W-1:0] letter_cnt,
    output logic [CNT_W-1:0] unknown_cnt,
    output logic             busy
);

    localparam logic [3:0] WaitLast = 4'(DONE_WAIT - 1);

    textState_t state, stateNext;
    logic [3:0] waitCnt;
    logic [4:0] mapIndex;
    logic       mapValid;
    logic       accept;

    char_mapper #(
        .MAXLETTERS(MAXLETTERS)
    ) u_mapper (
        .code (char_data),
        .index(mapIndex),
        .valid(mapValid)
    );

    // char_ready is registered and only ever 1 in STREAM
    assign accept = char_valid && char_ready;

    always_comb begin
        stateNext = state;
        unique case (state)
            StIdle:   if (char_valid) stateNext = StClear;
            StClear:  stateNext = StStream;
            StStream: if (accept && char_last) stateNext = StFlush;
            StFlush:  stateNext = StDone;
            StDone:   stateNext = StWait;
            StWait:   if (waitCnt == WaitLast) stateNext = StOut;
            StOut:    if (vec_ready) stateNext = StIdle;
            default:  stateNext = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= StIdle;
            char_ready  <= 1'b0;
            letterReady <= 1'b0;
            inputLetter <= '0;
            textDone    <= 1'b0;
            rst_RI      <= 1'b0;
            vec_valid   <= 1'b0;
            busy        <= 1'b0;
            letter_cnt  <= '0;
            unknown_cnt <= '0;
            waitCnt     <= '0;
        end else begin
            state       <= stateNext;
            char_ready  <= (stateNext == StStream);
            textDone    <= (stateNext == StDone);
            rst_RI      <= (stateNext != StClear);
            vec_valid   <= (stateNext == StOut);
            busy        <= (stateNext != StIdle);
            letterReady <= accept && mapValid;
            if (accept && mapValid) begin
                inputLetter <= mapIndex;
            end
            waitCnt <= (state == StWait) ? waitCnt + 4'd1 : 4'd0;

            // Counters hold their final values from DONE until the next CLEAR
            if (stateNext == StClear) begin
                letter_cnt  <= '0;
                unknown_cnt <= '0;
            end else if (accept) begin
                if (mapValid) begin
                    if (letter_cnt != '1) letter_cnt <= letter_cnt + 1'b1;
                end else begin
                    if (unknown_cnt != '1) unknown_cnt <= unknown_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_text_encoder_ctrl.sv
// Directed self-checking bench for text_encoder_ctrl (DONE_WAIT=3, CNT_W=3).
module tb_text_encoder_ctrl;

    localparam int unsigned CntW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            char_valid = 1'b0;
    logic [7:0]      char_data = 8'd0;
    logic            char_last = 1'b0;
    logic            char_ready;
    logic            letterReady;
    logic [4:0]      inputLetter;
    logic            textDone;
    logic            rst_RI;
    logic            vec_valid;
    logic            vec_ready = 1'b0;
    logic [CntW-1:0] letter_cnt;
    logic [CntW-1:0] unknown_cnt;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    int overlap = 0;
    int pBase;
    int dBase;
    logic [4:0] pulses[$];

    text_encoder_ctrl #(
        .MAXLETTERS(27),
        .CNT_W     (CntW),
        .DONE_WAIT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_last  (char_last),
        .char_ready (char_ready),
        .letterReady(letterReady),
        .inputLetter(inputLetter),
        .textDone   (textDone),
        .rst_RI     (rst_RI),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .letter_cnt (letter_cnt),
        .unknown_cnt(unknown_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (letterReady) pulses.push_back(inputLetter);
        if (textDone) doneCount++;
        if (letterReady && textDone) overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkResetOuts(input string tag);
        check({tag, "_char_ready"}, 32'(char_ready), 0);
        check({tag, "_letterReady"}, 32'(letterReady), 0);
        check({tag, "_inputLetter"}, 32'(inputLetter), 0);
        check({tag, "_textDone"}, 32'(textDone), 0);
        check({tag, "_rst_RI"}, 32'(rst_RI), 0);
        check({tag, "_vec_valid"}, 32'(vec_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_letter_cnt"}, 32'(letter_cnt), 0);
        check({tag, "_unknown_cnt"}, 32'(unknown_cnt), 0);
    endtask

    // Offers each character, waiting (bounded) for char_ready, then lets one edge accept it.
    task automatic sendText(input string s, input bit lastAtEnd);
        for (int i = 0; i < s.len(); i++) begin
            int n;
            char_valid = 1'b1;
            char_data  = s[i];
            char_last  = lastAtEnd && (i == s.len() - 1);
            n = 0;
            while (!char_ready && n < 20) begin
                tick();
                n++;
            end
            check("ready_wait", 32'(char_ready), 1);
            tick();
        end
        char_valid = 1'b0;
        char_last  = 1'b0;
    endtask

    // Called in FLUSH: DONE next, three WAIT cycles, then OUT and a handshake.
    task automatic finishText(input string tag);
        check({tag, "_flush_textDone"}, 32'(textDone), 0);
        check({tag, "_flush_ready"}, 32'(char_ready), 0);
        tick();
        check({tag, "_textDone"}, 32'(textDone), 1);
        check({tag, "_done_letterReady"}, 32'(letterReady), 0);
        for (int w = 0; w < 3; w++) begin
            tick();
            check({tag, "_wait_vec_valid"}, 32'(vec_valid), 0);
            check({tag, "_wait_textDone"}, 32'(textDone), 0);
        end
        tick();
        check({tag, "_vec_rise"}, 32'(vec_valid), 1);
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        check({tag, "_idle_busy"}, 32'(busy), 0);
        check({tag, "_idle_vec_valid"}, 32'(vec_valid), 0);
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        checkResetOuts("reset");
        rst = 1'b1;
        tick();
        check("idle_rst_RI", 32'(rst_RI), 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_ready", 32'(char_ready), 0);

        // "ab c": expect indices 0,1,26,2
        pBase = pulses.size();
        dBase = doneCount;
        char_valid = 1'b1;
        char_data  = "a";
        tick();
        check("clear_rst_RI", 32'(rst_RI), 0);
        check("clear_busy", 32'(busy), 1);
        check("clear_ready", 32'(char_ready), 0);
        sendText("ab c", 1'b1);
        check("abc_flush_pulse", 32'(letterReady), 1);
        check("abc_flush_idx", 32'(inputLetter), 2);
        tick();
        check("abc_textDone", 32'(textDone), 1);
        check("abc_letter_cnt", 32'(letter_cnt), 4);
        check("abc_unknown_cnt", 32'(unknown_cnt), 0);
        for (int w = 0; w < 4; w++) tick();
        check("abc_vec_valid", 32'(vec_valid), 1);
        // Stall in OUT while a character is offered
        char_valid = 1'b1;
        char_data  = "x";
        for (int w = 0; w < 10; w++) begin
            tick();
            check("stall_vec_valid", 32'(vec_valid), 1);
            check("stall_ready", 32'(char_ready), 0);
        end
        char_valid = 1'b0;
        vec_ready  = 1'b1;
        tick();
        vec_ready = 1'b0;
        check("hs_busy", 32'(busy), 0);
        check("hs_vec_valid", 32'(vec_valid), 0);
        check("hs_letter_cnt_stable", 32'(letter_cnt), 4);
        check("abc_pulse_count", 32'(pulses.size() - pBase), 4);
        check("abc_p0", 32'(pulses[pBase]), 0);
        check("abc_p1", 32'(pulses[pBase+1]), 1);
        check("abc_p2", 32'(pulses[pBase+2]), 26);
        check("abc_p3", 32'(pulses[pBase+3]), 2);
        check("abc_done_count", 32'(doneCount - dBase), 1);

        // "a1!b": two pulses, two unknowns
        pBase = pulses.size();
        sendText("a1!b", 1'b1);
        finishText("a1b");
        check("a1b_pulse_count", 32'(pulses.size() - pBase), 2);
        check("a1b_p0", 32'(pulses[pBase]), 0);
        check("a1b_p1", 32'(pulses[pBase+1]), 1);
        check("a1b_letter_cnt", 32'(letter_cnt), 2);
        check("a1b_unknown_cnt", 32'(unknown_cnt), 2);

        // 'Q' alone
        pBase = pulses.size();
        dBase = doneCount;
        sendText("Q", 1'b1);
        finishText("q");
        check("q_done_count", 32'(doneCount - dBase), 1);
`ifdef TEXT_CTRL_UPPERCASE_EN
        check("q_pulse_count", 32'(pulses.size() - pBase), 1);
        check("q_idx", 32'(pulses[pBase]), 16);
        check("q_letter_cnt", 32'(letter_cnt), 1);
        check("q_unknown_cnt", 32'(unknown_cnt), 0);
`else
        check("q_pulse_count", 32'(pulses.size() - pBase), 0);
        check("q_letter_cnt", 32'(letter_cnt), 0);
        check("q_unknown_cnt", 32'(unknown_cnt), 1);
`endif

        // Single unknown character still runs the full sequence
        pBase = pulses.size();
        sendText("#", 1'b1);
        finishText("unk");
        check("unk_pulse_count", 32'(pulses.size() - pBase), 0);
        check("unk_letter_cnt", 32'(letter_cnt), 0);
        check("unk_unknown_cnt", 32'(unknown_cnt), 1);

        // Saturation of 3-bit counters
        sendText("abcdefghij1234567890", 1'b1);
        finishText("sat");
        check("sat_letter_cnt", 32'(letter_cnt), 7);
        check("sat_unknown_cnt", 32'(unknown_cnt), 7);

        // Reset mid-text after five letters
        dBase = doneCount;
        sendText("hello", 1'b0);
        check("mid_letter_cnt", 32'(letter_cnt), 5);
        rst = 1'b0;
        tick();
        checkResetOuts("midrst");
        rst = 1'b1;
        repeat (6) tick();
        check("midrst_no_done", 32'(doneCount - dBase), 0);
        check("midrst_idle_busy", 32'(busy), 0);
        pBase = pulses.size();
        char_valid = 1'b1;
        char_data  = "z";
        tick();
        check("restart_clear_rst_RI", 32'(rst_RI), 0);
        tick();
        check("restart_rst_RI_high", 32'(rst_RI), 1);
        sendText("z", 1'b1);
        finishText("restart");
        check("restart_pulse_count", 32'(pulses.size() - pBase), 1);
        check("restart_idx", 32'(pulses[pBase]), 25);
        check("restart_letter_cnt", 32'(letter_cnt), 1);
        check("no_overlap", 32'(overlap), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
